// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the data memory arbiter
package mem_arb_pkg;

  // Arbiter sequencing: sample requests, strobe memory, report completion
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  // Number of addressable words when the instantiating design does not override it
  localparam int unsigned MEM_DEPTH_DEFAULT = 256;

endpackage

// File: rtl/mem_rr_pick.sv
// rtl/mem_rr_pick.sv - two-way round-robin winner selection
module mem_rr_pick
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_id,
  output logic o_valid
);

  // A lone requester wins outright; on a tie the port not served last wins
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_id    = 1'b0;
    if (i_req0 && i_req1) begin
      o_id = ~i_last;
    end else if (i_req1) begin
      o_id = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin arbiter in front of a single data memory
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  // One extra bit so a depth equal to 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_last;
  logic              r_id;
  logic              r_we;
  logic              r_oor;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_p0_ack;
  logic              r_p1_ack;
  logic              r_p0_err;
  logic              r_p1_err;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;

  logic              w_pick_id;
  logic              w_pick_valid;
  logic              w_grant;
  logic              w_respond;
  logic              w_mem_read;
  logic              w_mem_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_we;
  logic              w_sel_oor;

  mem_rr_pick u_pick (
    .i_req0  (p0_req),
    .i_req1  (p1_req),
    .i_last  (r_last),
    .o_id    (w_pick_id),
    .o_valid (w_pick_valid)
  );

  assign w_sel_addr  = w_pick_id ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_pick_id ? p1_wdata : p0_wdata;
  assign w_sel_we    = w_pick_id ? p1_we    : p0_we;
  assign w_sel_oor   = ({1'b0, w_sel_addr} >= LP_DEPTH);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the single-cycle controls each state produces
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_respond   = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = ACCESS;
          w_grant     = 1'b1;
        end
      end
      ACCESS: begin
        w_state_nxt = DONE;
        w_respond   = 1'b1;
        w_mem_read  = ~r_we & ~r_oor;
        w_mem_write =  r_we & ~r_oor;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture the winning request so later input changes cannot disturb it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_id    <= w_pick_id;
      r_we    <= w_sel_we;
      r_oor   <= w_sel_oor;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

  // Completion: ack/err become visible during DONE together with fresh read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_p0_err   <= 1'b0;
      r_p1_err   <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;
      r_p0_err <= 1'b0;
      r_p1_err <= 1'b0;
      if (w_respond) begin
        if (r_id == 1'b0) begin
          r_p0_ack <= 1'b1;
          r_p0_err <= r_oor;
          if (!r_we) begin
            r_p0_rdata <= r_oor ? '0 : mem_read_data;
          end
        end else begin
          r_p1_ack <= 1'b1;
          r_p1_err <= r_oor;
          if (!r_we) begin
            r_p1_rdata <= r_oor ? '0 : mem_read_data;
          end
        end
      end
    end
  end

  // Remember who was served so the next tie goes to the other port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (r_state == DONE) begin
      r_last <= r_id;
    end
  end

  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;
  assign mem_read       = w_mem_read;
  assign mem_write      = w_mem_write;
  assign p0_ack         = r_p0_ack;
  assign p1_ack         = r_p1_ack;
  assign p0_err         = r_p0_err;
  assign p1_err         = r_p1_err;
  assign p0_rdata       = r_p0_rdata;
  assign p1_rdata       = r_p1_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;
  logic        init_mem;

  logic [31:0] bus_mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] m_rd [0:1];

  int n_pass;
  int n_total;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        drop;
    logic        exp_rd;
    logic        exp_wr;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [0:10];

  data_mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .p0_req         (p0_req),
    .p0_we          (p0_we),
    .p0_addr        (p0_addr),
    .p0_wdata       (p0_wdata),
    .p0_ack         (p0_ack),
    .p0_err         (p0_err),
    .p0_rdata       (p0_rdata),
    .p1_req         (p1_req),
    .p1_we          (p1_we),
    .p1_addr        (p1_addr),
    .p1_wdata       (p1_wdata),
    .p1_ack         (p1_ack),
    .p1_err         (p1_err),
    .p1_rdata       (p1_rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // Asynchronous-read data memory with a synchronous write port
  assign mem_read_data = (mem_address < 32'd256) ? bus_mem[mem_address[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) bus_mem[i] <= init_word(i);
    end else if (mem_write && mem_address < 32'd256) begin
      bus_mem[mem_address[7:0]] <= mem_write_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_rd[0] = 32'h0;
    m_rd[1] = 32'h0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   o;
    v = tbl[idx];
    o = v.port ? 0 : 1;
    drive(int'(v.port), 1'b1, v.we, v.addr, v.wdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d_mem_read", idx), 32'(mem_read), 32'(v.exp_rd));
    chk($sformatf("v%0d_mem_write", idx), 32'(mem_write), 32'(v.exp_wr));
    chk($sformatf("v%0d_early_ack", idx), 32'(p0_ack | p1_ack), 32'h0);
    if (v.exp_rd || v.exp_wr) chk($sformatf("v%0d_mem_addr", idx), mem_address, v.addr);
    if (v.exp_wr) chk($sformatf("v%0d_mem_wdata", idx), mem_write_data, v.wdata);
    if (v.drop) drive(int'(v.port), 1'b0, v.we, v.addr, v.wdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d_ack", idx), 32'(v.port ? p1_ack : p0_ack), 32'h1);
    chk($sformatf("v%0d_other_ack", idx), 32'(v.port ? p0_ack : p1_ack), 32'h0);
    chk($sformatf("v%0d_err", idx), 32'(v.port ? p1_err : p0_err), 32'(v.exp_err));
    chk($sformatf("v%0d_rdata", idx), v.port ? p1_rdata : p0_rdata, v.exp_rdata);
    chk($sformatf("v%0d_other_rdata", idx), v.port ? p0_rdata : p1_rdata, m_rd[o]);
    chk($sformatf("v%0d_strobe_off", idx), 32'(mem_read | mem_write), 32'h0);
    chk($sformatf("v%0d_addr_hold", idx), mem_address, v.addr);
    m_rd[v.port] = v.exp_rdata;
    drive(int'(v.port), 1'b0, v.we, v.addr, v.wdata);
    @(posedge clk); #1;
  endtask

  initial begin
    int   ack_cyc[$];
    int   ack_id[$];
    logic ack_seen;
    int   st [0:1];
    logic rq_we [0:1];
    logic [31:0] rq_addr [0:1];
    logic [31:0] rq_wd [0:1];
    int   next_free, gw, pw;
    logic gv, pv, m_last, oor;

    n_pass = 0;
    n_total = 0;
    //            port  we    addr          wdata         drop  rd    wr    err   rdata
    tbl[0]  = '{1'b0, 1'b1, 32'd5,        32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'd5,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 32'd256,      32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'd3,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hC0DE0003};
    tbl[4]  = '{1'b0, 1'b1, 32'd9,        32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 1'b0, 32'd9,        32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h12345678};
    tbl[6]  = '{1'b1, 1'b1, 32'd255,      32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC0DE0003};
    tbl[7]  = '{1'b1, 1'b0, 32'd255,      32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5};
    tbl[8]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 32'd300,      32'h11111111, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'd0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hC0DE0000};

    // Reset values, observed while reset is still held
    init_mem = 1'b1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p0_ack", 32'(p0_ack), 32'h0);
    chk("rst_p1_ack", 32'(p1_ack), 32'h0);
    chk("rst_p0_err", 32'(p0_err), 32'h0);
    chk("rst_p1_err", 32'(p1_err), 32'h0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_p1_rdata", p1_rdata, 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_addr", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    init_mem = 1'b0;
    rst_n = 1'b1;

    // Both ports held from reset: p0 first, then alternating, acks 3 cycles apart
    drive(0, 1'b1, 1'b0, 32'd1, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd2, 32'h0);
    for (int c = 1; c <= 20 && ack_id.size() < 4; c++) begin
      @(posedge clk); #1;
      if (p0_ack) begin ack_id.push_back(0); ack_cyc.push_back(c); end
      if (p1_ack) begin ack_id.push_back(1); ack_cyc.push_back(c); end
    end
    chk("rr_ack_count", 32'(ack_id.size()), 32'd4);
    for (int i = 0; i < ack_id.size(); i++) begin
      chk($sformatf("rr_order%0d", i), 32'(ack_id[i]), 32'(i % 2));
      chk($sformatf("rr_cycle%0d", i), 32'(ack_cyc[i]), 32'(2 + 3 * i));
    end
    do_reset();

    // Single-port transactions from the table
    for (int i = 0; i < 11; i++) run_vec(i);

    // Address change after grant must not reach the memory
    drive(0, 1'b1, 1'b0, 32'd7, 32'h0);
    @(posedge clk); #1;
    p0_addr = 32'd9;
    #1;
    chk("hold_mem_addr", mem_address, 32'd7);
    chk("hold_mem_read", 32'(mem_read), 32'h1);
    @(posedge clk); #1;
    chk("hold_ack", 32'(p0_ack), 32'h1);
    chk("hold_rdata", p0_rdata, init_word(7));
    drive(0, 1'b0, 1'b0, 32'd9, 32'h0);
    @(posedge clk); #1;

    // Reset in the middle of a p1 write
    drive(1, 1'b1, 1'b1, 32'd10, 32'hBAD0BAD0);
    @(posedge clk); #1;
    chk("abort_write_on", 32'(mem_write), 32'h1);
    #2;
    rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, 32'd0, 32'h0);
    #1;
    chk("abort_write_off", 32'(mem_write), 32'h0);
    chk("abort_p1_rdata", p1_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_rd[0] = 32'h0;
    m_rd[1] = 32'h0;
    ack_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      ack_seen = ack_seen | p0_ack | p1_ack;
    end
    chk("abort_no_ack", 32'(ack_seen), 32'h0);
    chk("abort_mem_untouched", bus_mem[10], init_word(10));
    drive(0, 1'b1, 1'b0, 32'd1, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd2, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_tie_p0_ack", 32'(p0_ack), 32'h1);
    chk("abort_tie_p1_ack", 32'(p1_ack), 32'h0);
    do_reset();

    // Randomized traffic against a transaction-level model
    for (int i = 0; i < 256; i++) ref_mem[i] = bus_mem[i];
    st[0] = 0; st[1] = 0;
    m_last = 1'b1;
    next_free = 0;
    gv = 1'b0; gw = 0; pv = 1'b0; pw = 0;
    for (int e = 0; e < 400; e++) begin
      for (int p = 0; p < 2; p++) begin
        if (st[p] == 0 && $urandom_range(0, 2) != 0) begin
          st[p] = 1;
          rq_we[p] = 1'($urandom_range(0, 1));
          rq_addr[p] = ($urandom_range(0, 7) == 0) ? 32'(256 + $urandom_range(0, 2))
                                                   : 32'($urandom_range(0, 255));
          rq_wd[p] = $urandom;
          drive(p, 1'b1, rq_we[p], rq_addr[p], rq_wd[p]);
        end
      end
      @(posedge clk);
      pv = gv; pw = gw; gv = 1'b0;
      if (e >= next_free && (st[0] == 1 || st[1] == 1)) begin
        if (st[0] == 1 && st[1] == 1) gw = m_last ? 0 : 1;
        else gw = (st[1] == 1) ? 1 : 0;
        gv = 1'b1;
        st[gw] = 2;
        m_last = (gw == 1);
        next_free = e + 3;
      end
      #1;
      chk("rnd_mem_read", 32'(mem_read), 32'(gv && !rq_we[gw] && rq_addr[gw] < 32'd256));
      chk("rnd_mem_write", 32'(mem_write), 32'(gv && rq_we[gw] && rq_addr[gw] < 32'd256));
      if (gv && rq_addr[gw] < 32'd256) chk("rnd_mem_addr", mem_address, rq_addr[gw]);
      oor = pv && (rq_addr[pw] >= 32'd256);
      if (pv) begin
        if (!rq_we[pw]) m_rd[pw] = oor ? 32'h0 : ref_mem[rq_addr[pw][7:0]];
        else if (!oor) ref_mem[rq_addr[pw][7:0]] = rq_wd[pw];
      end
      chk("rnd_p0_ack", 32'(p0_ack), 32'(pv && pw == 0));
      chk("rnd_p1_ack", 32'(p1_ack), 32'(pv && pw == 1));
      chk("rnd_p0_err", 32'(p0_err), 32'(oor && pw == 0));
      chk("rnd_p1_err", 32'(p1_err), 32'(oor && pw == 1));
      chk("rnd_p0_rdata", p0_rdata, m_rd[0]);
      chk("rnd_p1_rdata", p1_rdata, m_rd[1]);
      if (pv) begin
        st[pw] = 0;
        drive(pw, 1'b0, rq_we[pw], rq_addr[pw], rq_wd[pw]);
      end
      if (gv && $urandom_range(0, 1) == 1) drive(gw, 1'b0, rq_we[gw], rq_addr[gw], rq_wd[gw]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
